// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, receiver state encoding and
// the bit-period helper used by both uart_rx and uart_tx.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bundle: byte, valid strobe, framing error, busy.
// master = uart_rx (drives), slave = consumer logic (reads).
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 rx_busy;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output rx_busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input frame_err,
        input rx_busy
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input.
// Ports: clk, rst (async, active-high), i_d (async in), o_q (synced out).
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and framing-error detection.
// Ports: clk, rst (async, active-high), i_rx (serial line),
//        rx_if (master: rx_data, rx_valid, frame_err, rx_busy).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_rx,
    uart_rx_if.master rx_if
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;

    localparam logic [15:0] C_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] C_HALF_LAST = 16'(HALF_BIT - 1);
    localparam logic [2:0]  C_LAST_IDX  = 3'(DATA_BITS - 1);

    logic                 w_rx_s;
    uart_state_e          r_state;
    uart_state_e          w_next;
    logic [15:0]          r_cnt;
    logic [15:0]          w_cnt_next;
    logic [2:0]           r_bit;
    logic [2:0]           w_bit_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [DATA_BITS-1:0] r_data;
    logic [DATA_BITS-1:0] w_data_next;
    logic                 r_valid;
    logic                 w_valid_next;
    logic                 r_err;
    logic                 w_err_next;
    logic                 w_half;
    logic                 w_full;

    // Resets high so leaving reset never looks like a start edge.
    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (i_rx),
        .o_q (w_rx_s)
    );

    assign w_half = (r_cnt == C_HALF_LAST);
    assign w_full = (r_cnt == C_BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt + 16'd1;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_data_next  = r_data;
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (!w_rx_s) begin
                    w_next     = START;
                    w_bit_next = '0;
                end
            end
            START: begin
                // Half a bit in: still low means a real start bit.
                if (w_half) begin
                    w_cnt_next = '0;
                    w_next     = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_full) begin
                    w_cnt_next   = '0;
                    w_shift_next = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_bit_next   = r_bit + 3'd1;
                    if (r_bit == C_LAST_IDX) begin
                        w_next = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop gives half a bit to catch the next start.
                if (w_full) begin
                    w_cnt_next = '0;
                    if (w_rx_s) begin
                        w_data_next  = r_shift;
                        w_valid_next = 1'b1;
                        w_next       = IDLE;
                    end else begin
                        w_err_next = 1'b1;
                        w_next     = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // A break must end before another frame can start.
                w_cnt_next = '0;
                if (w_rx_s) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_cnt_next = '0;
                w_next     = IDLE;
            end
        endcase
    end

    assign rx_if.rx_data   = r_data;
    assign rx_if.rx_valid  = r_valid;
    assign rx_if.frame_err = r_err;
    assign rx_if.rx_busy   = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames queue expected pulses,
// a negedge monitor pops and checks kind, cycle, data and busy.
module tb_uart_rx;

    localparam int CLK_FREQ = 1600;
    localparam int BAUD     = 100;
    localparam int CPB      = 16;
    localparam int HALF     = 8;
    // drive edge -> 2 sync flops -> T0 -> stop sample at T0+HALF+9*CPB
    localparam int LAT      = 3 + HALF + 9 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    uart_rx_if u_if();

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .i_rx  (rx),
        .rx_if (u_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         t;
    } exp_t;

    exp_t q[$];
    int   errors  = 0;
    int   checks  = 0;
    int   n_valid = 0;
    int   n_err   = 0;
    bit   prev_v  = 0;
    bit   prev_e  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (u_if.rx_valid || u_if.frame_err)) begin
            exp_t e;
            if (u_if.rx_valid) n_valid++;
            if (u_if.frame_err) n_err++;
            check("pulse_exclusive", 32'(u_if.rx_valid & u_if.frame_err), 0);
            check("single_cycle",
                  32'((prev_v & u_if.rx_valid) | (prev_e & u_if.frame_err)), 0);
            if (q.size() == 0) begin
                check("unexpected_pulse", 32'(q.size()), 1);
            end else begin
                e = q.pop_front();
                check("pulse_kind", 32'(u_if.frame_err), 32'(e.is_err));
                check("pulse_cycle", cyc, e.t);
                check("busy_at_pulse", 32'(u_if.rx_busy), 32'(e.is_err));
                if (!e.is_err) check("rx_data", 32'(u_if.rx_data), 32'(e.data));
            end
        end
        prev_v = u_if.rx_valid;
        prev_e = u_if.frame_err;
    end

    // Caller must be at a negedge; leaves rx at the stop level.
    task automatic send(input logic [7:0] b, input logic stop, input bit push);
        if (push) q.push_back('{is_err: !stop, data: b, t: cyc + LAT});
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(q.size()), 0);
    endtask

    initial begin
        int base_v;
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data",  32'(u_if.rx_data), 0);
        check("rst_valid", 32'(u_if.rx_valid), 0);
        check("rst_err",   32'(u_if.frame_err), 0);
        check("rst_busy",  32'(u_if.rx_busy), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(u_if.rx_busy), 0);

        // 1: single good frame
        send(8'hA5, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        drain("t1_drain");
        check("t1_count", n_valid, 1);
        check("t1_hold", 32'(u_if.rx_data), 32'h A5);

        // 2: back-to-back frames, no idle gap
        send(8'h00, 1'b1, 1'b1);
        send(8'hFF, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        drain("t2_drain");
        check("t2_count", n_valid, 3);
        check("t2_data", 32'(u_if.rx_data), 32'h FF);

        // 3: 4-cycle glitch is rejected
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        check("t3_busy_rise", 32'(u_if.rx_busy), 1);
        repeat (10) @(negedge clk);
        check("t3_busy_fall", 32'(u_if.rx_busy), 0);
        check("t3_no_valid", n_valid, 3);
        check("t3_no_err", n_err, 0);
        send(8'h3C, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        drain("t3_drain");
        check("t3_data", 32'(u_if.rx_data), 32'h 3C);

        // 4: bad stop bit then a long break
        send(8'h3C, 1'b0, 1'b1);
        repeat (100) @(negedge clk);
        check("t4_busy_break", 32'(u_if.rx_busy), 1);
        check("t4_err_count", n_err, 1);
        check("t4_valid_count", n_valid, 4);
        check("t4_data_kept", 32'(u_if.rx_data), 32'h 3C);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_busy_fall", 32'(u_if.rx_busy), 0);
        send(8'h81, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        drain("t4_drain");
        check("t4_data", 32'(u_if.rx_data), 32'h 81);

        // 5: reset during data bit 4
        fork
            send(8'h5A, 1'b1, 1'b0);
        join_none
        repeat (88) @(negedge clk);
        check("t5_busy_pre", 32'(u_if.rx_busy), 1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_data",  32'(u_if.rx_data), 0);
        check("t5_rst_valid", 32'(u_if.rx_valid), 0);
        check("t5_rst_err",   32'(u_if.frame_err), 0);
        check("t5_rst_busy",  32'(u_if.rx_busy), 0);
        wait fork;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_idle", 32'(u_if.rx_busy), 0);
        check("t5_no_pulse", n_valid, 5);
        send(8'h5A, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        drain("t5_drain");
        check("t5_data", 32'(u_if.rx_data), 32'h 5A);

        // 6: loopback sweep of every byte value
        base_v = n_valid;
        for (int b = 0; b < 256; b++) begin
            send(8'(b), 1'b1, 1'b1);
        end
        repeat (4) @(negedge clk);
        drain("t6_drain");
        check("t6_count", n_valid - base_v, 256);
        check("t6_no_err", n_err, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
